// File: rtl/vga_80x60_scanout.sv
// 640x480@60 scanout of the 80x60 RRRGGGBB framebuffer, 8x8 upscale.
// Optional VGA_TEST_PATTERN_EN adds TEST_MODE (8 vertical colour bars).
module vga_80x60_scanout #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic        CLK_50MHz,
  input  logic        RST,
`ifdef VGA_TEST_PATTERN_EN
  input  logic        TEST_MODE,
`endif
  output logic [12:0] RA2,
  input  logic [7:0]  RD2,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic [3:0]  VGA_R,
  output logic [3:0]  VGA_G,
  output logic [3:0]  VGA_B,
  output logic        VBLANK,
  output logic        FRAME_TICK
);

  localparam int HT  = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int VT  = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HS0 = H_VISIBLE + H_FP;
  localparam int HS1 = HS0 + H_SYNC - 1;
  localparam int VS0 = V_VISIBLE + V_FP;
  localparam int VS1 = VS0 + V_SYNC - 1;

  logic       px_en_q;
  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] vcnt_q, vcnt_d;
  logic       hs_q, vs_q, vblank_q, tick_q;
  logic [3:0] r_q, g_q, b_q;

  logic       h_last, v_last, active;
  logic [7:0] pix;
  logic       hs_d, vs_d, vblank_d, tick_d;
  logic [3:0] r_d, g_d, b_d;

  assign h_last = (hcnt_q == 10'(HT - 1));
  assign v_last = (vcnt_q == 10'(VT - 1));

  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (px_en_q) begin
      if (h_last) begin
        hcnt_d = '0;
        vcnt_d = v_last ? '0 : vcnt_q + 10'd1;
      end else begin
        hcnt_d = hcnt_q + 10'd1;
      end
    end
  end

  assign active = (hcnt_q < 10'(H_VISIBLE))
               && (vcnt_q < 10'(V_VISIBLE));

  // Blank-time address parks at 0 so RA2 never leaves the RAM.
  assign RA2 = active ? {vcnt_q[8:3], hcnt_q[9:3]} : '0;

`ifdef VGA_TEST_PATTERN_EN
  logic [6:0] col;
  logic [2:0] bar;
  assign col = hcnt_q[9:3];
  assign bar = 3'(col / 7'd10);
  assign pix = TEST_MODE
             ? {{3{bar[2]}}, {3{bar[1]}}, {2{bar[0]}}}
             : RD2;
`else
  assign pix = RD2;
`endif

  always_comb begin
    hs_d     = !((hcnt_q >= 10'(HS0)) && (hcnt_q <= 10'(HS1)));
    vs_d     = !((vcnt_q >= 10'(VS0)) && (vcnt_q <= 10'(VS1)));
    vblank_d = (vcnt_q >= 10'(V_VISIBLE));
    tick_d   = px_en_q && (hcnt_q == '0)
            && (vcnt_q == 10'(V_VISIBLE));
    r_d      = '0;
    g_d      = '0;
    b_d      = '0;
    if (active) begin
      r_d = {pix[7:5], pix[7]};
      g_d = {pix[4:2], pix[4]};
      b_d = {pix[1:0], pix[1:0]};
    end
  end

  always_ff @(posedge CLK_50MHz) begin
    if (RST) begin
      px_en_q  <= 1'b0;
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
      vblank_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      px_en_q <= ~px_en_q;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      tick_q  <= tick_d;
      if (px_en_q) begin
        hs_q     <= hs_d;
        vs_q     <= vs_d;
        r_q      <= r_d;
        g_q      <= g_d;
        b_q      <= b_d;
        vblank_q <= vblank_d;
      end
    end
  end

  assign VGA_HS     = hs_q;
  assign VGA_VS     = vs_q;
  assign VGA_R      = r_q;
  assign VGA_G      = g_q;
  assign VGA_B      = b_q;
  assign VBLANK     = vblank_q;
  assign FRAME_TICK = tick_q;

endmodule

// File: tb/tb_vga_80x60_scanout.sv
// Bench for vga_80x60_scanout: pixel-index model checked every cycle.
// Vertical timing is shortened so a whole frame fits in a short run.
module tb_vga_80x60_scanout;

  localparam int HT  = 800;
  localparam int VV  = 24;
  localparam int VFP = 2;
  localparam int VSY = 2;
  localparam int VBP = 3;
  localparam int VT  = VV + VFP + VSY + VBP;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tm  = 1'b0;
  int          mode = 0;
  logic [12:0] ra2;
  logic [7:0]  rd2;
  logic        hs, vs, vb, ft;
  logic [3:0]  r, g, b;

  always #10 clk = ~clk;

  vga_80x60_scanout #(
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
  ) dut (
    .CLK_50MHz (clk),
    .RST       (rst),
`ifdef VGA_TEST_PATTERN_EN
    .TEST_MODE (tm),
`endif
    .RA2       (ra2),
    .RD2       (rd2),
    .VGA_HS    (hs),
    .VGA_VS    (vs),
    .VGA_R     (r),
    .VGA_G     (g),
    .VGA_B     (b),
    .VBLANK    (vb),
    .FRAME_TICK(ft)
  );

  // RAM stand-in: byte = address[7:0], or a forced constant.
  always_comb begin
    rd2 = ra2[7:0];
    if (mode == 1) rd2 = 8'hFF;
    if (mode == 2) rd2 = 8'h00;
  end

  int checks = 0;
  int errors = 0;
  int t = 0;
  bit live = 0;
  int upd_mode = 0;
  bit upd_tm = 0;
  bit prev_hs = 1, prev_vb = 0;
  bit fall_seen = 0;
  int last_fall = 0;
  int run130 = 0;
  int ticks = 0;
  int first_falls = 0;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0d got %0h want %0h", nm, t, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(int h, int v, int md, bit tmode);
    logic [2:0] bb;
    int a;
    if (tmode) begin
      bb = 3'((h / 8) / 10);
      return {{3{bb[2]}}, {3{bb[1]}}, {2{bb[0]}}};
    end
    if (md == 1) return 8'hFF;
    if (md == 2) return 8'h00;
    a = (v / 8) * 128 + h / 8;
    return 8'(a);
  endfunction

  task automatic check_cycle(int ms, bit ts);
    int p, ph, pv, q, h, v;
    int ea;
    bit act;
    logic [7:0] bv;
    int e_hs, e_vs, e_r, e_g, e_b, e_vb, e_ft;
    p  = t / 2;
    ph = p % HT;
    pv = (p / HT) % VT;
    ea = (ph < 640 && pv < VV) ? (pv / 8) * 128 + ph / 8 : 0;
    chk("ra2", int'(ra2), ea);
    if (ph == 17 && pv == 9) chk("ra2_17_9", int'(ra2), 130);
    if (ra2 == 13'd130) run130++;
    else begin
      if (run130 > 0) chk("ra2_hold", run130, 16);
      run130 = 0;
    end

    if (t >= 2 && t % 2 == 0) begin
      upd_mode = ms;
      upd_tm   = ts;
    end
    h = 0; v = 0;
    if (t < 2) begin
      e_hs = 1; e_vs = 1; e_r = 0; e_g = 0; e_b = 0;
      e_vb = 0; e_ft = 0;
    end else begin
      q = t / 2 - 1;
      h = q % HT;
      v = (q / HT) % VT;
      act = (h < 640) && (v < VV);
      bv = exp_byte(h, v, upd_mode, upd_tm);
      e_hs = (h >= 656 && h <= 751) ? 0 : 1;
      e_vs = (v >= VV + VFP && v <= VV + VFP + VSY - 1) ? 0 : 1;
      e_r  = act ? int'({bv[7:5], bv[7]}) : 0;
      e_g  = act ? int'({bv[4:2], bv[4]}) : 0;
      e_b  = act ? int'({bv[1:0], bv[1:0]}) : 0;
      e_vb = (v >= VV) ? 1 : 0;
      e_ft = (t % 2 == 0 && h == 0 && v == VV) ? 1 : 0;
    end
    chk("hs", int'(hs), e_hs);
    chk("vs", int'(vs), e_vs);
    chk("r", int'(r), e_r);
    chk("g", int'(g), e_g);
    chk("b", int'(b), e_b);
    chk("vblank", int'(vb), e_vb);
    chk("frame_tick", int'(ft), e_ft);

    if (t == 0) begin
      chk("rst_hs", int'(hs), 1);
      chk("rst_vs", int'(vs), 1);
      chk("rst_rgb", int'({r, g, b}), 0);
      chk("rst_vb_ft", int'({vb, ft}), 0);
    end
    if (t >= 2 && t % 2 == 0 && h == 17 && v == 9
        && upd_mode == 0 && !upd_tm) begin
      chk("px17_9_r", int'(r), 4'h9);
      chk("px17_9_g", int'(g), 4'h0);
      chk("px17_9_b", int'(b), 4'hA);
    end
    if (t >= 2 && t % 2 == 0 && h == 100 && v < VV
        && upd_mode == 1 && !upd_tm)
      chk("ff_rgb", int'({r, g, b}), 12'hFFF);
`ifdef VGA_TEST_PATTERN_EN
    if (t >= 2 && t % 2 == 0 && h == 250 && v < VV && upd_tm) begin
      chk("bar3_r", int'(r), 4'h0);
      chk("bar3_g", int'(g), 4'hF);
      chk("bar3_b", int'(b), 4'hF);
    end
`endif

    if (t == 0) fall_seen = 0;
    if (prev_hs && !hs) begin
      if (!fall_seen) begin
        chk("hs_first_fall", t, 1314);
        first_falls++;
      end else begin
        chk("line_period", t - last_fall, 1600);
      end
      fall_seen = 1;
      last_fall = t;
    end
    if (!prev_hs && hs && fall_seen)
      chk("hs_low_width", t - last_fall, 192);
    if (ft) begin
      ticks++;
      chk("tick_vblank", int'(vb), 1);
      chk("tick_vb_rise", int'(prev_vb), 0);
    end
    prev_hs = hs;
    prev_vb = vb;
  endtask

  always @(posedge clk) begin
    int ms;
    bit rs, ts;
    rs = rst;
    ms = mode;
    ts = tm;
    #1;
    if (rs) begin
      t = 0;
      live = 1;
    end else if (live) begin
      t++;
    end
    if (live) check_cycle(ms, ts);
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (19200) @(negedge clk);
    mode = 1;
    repeat (6400) @(negedge clk);
    mode = 0;
`ifdef VGA_TEST_PATTERN_EN
    tm = 1'b1;
    mode = 2;
`endif
    repeat (3200) @(negedge clk);
    tm = 1'b0;
    mode = 0;
    // Reset lands with the counters at (700, 10) of the second frame.
    repeat (38200) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2000) @(negedge clk);
    chk("tick_count", ticks, 1);
    chk("first_fall_count", first_falls, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
